mem_arbiter: RTL
================

# mem_arbiter

Two-client arbiter that shares the single 128-bit block memory port between the instruction cache (client 0) and the data cache (client 1). It sits between the two cache instances and the memory model, and decides each contest with round-robin priority. It forwards exactly one block transaction at a time: either a read (allocate) or a write (writeback). Client-facing signalling matches the cache memory interface, so each cache connects unchanged.

## Interface
- ADDR_W, 28, block address width (word address without the 2 word-offset bits)
- DATA_W, 128, block data width
- clk  in  1  sole clock, rising edge
- proc_reset  in  1  reset; one clock; reset is asynchronous and active-low
- c0_read / c1_read  in  1  client block-read request, held high until its ready
- c0_write / c1_write  in  1  client block-write request, held high until its ready
- c0_addr / c1_addr  in  ADDR_W  client block address
- c0_wdata / c1_wdata  in  DATA_W  client write data
- c0_rdata / c1_rdata  out  DATA_W  read data: mem_rdata passed straight through to both clients
- c0_ready / c1_ready  out  1  completion pulse, asserted only for the granted client
- mem_read  out  1  memory read command, registered
- mem_write  out  1  memory write command, registered
- mem_addr  out  ADDR_W  latched address of the granted command, registered
- mem_wdata  out  DATA_W  latched write data, registered
- mem_rdata  in  DATA_W  memory read data, valid while mem_ready is high
- mem_ready  in  1  memory completion, one or more cycles after the command

## Operation
- A client requests when its read or write is high. If both are high, the request is treated as a write.
- States:
  - IDLE: no command outstanding.
  - BUSY: command driven to memory, waiting for mem_ready.
  - RELEASE: one cycle in which no grant is made, so the finished client can drop its registered request.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both request: grant the client that is not last_grant. last_grant then takes the granted index.
  - On grant, latch that client's addr, wdata and command type into the mem_* registers, set mem_read or mem_write, and go to BUSY.
- BUSY:
  - mem_* outputs are held constant. Client input changes are ignored.
  - cN_ready = mem_ready for the granted client N; the other client's ready is 0.
  - On mem_ready: clear mem_read and mem_write (registered), clear mem_addr and mem_wdata to 0, and go to RELEASE.
- RELEASE: always go to IDLE. mem_ready is ignored.
- mem_ready seen in IDLE or RELEASE is ignored and never reaches a client.
- Both mem_read and mem_write high at the same time must never occur; the bench asserts this.
- Reset values:
  - state = IDLE, last_grant = 1 (client 0 wins the first tie).
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - c0_ready = 0, c1_ready = 0.
- Reset asserted mid-transaction: all registers clear immediately without waiting for a clock. The transaction is abandoned and is not replayed after reset.

## Timing
- Request high at rising edge t while in IDLE → mem_read or mem_write high from t+1.
- mem_ready high during cycle k → cN_ready high in the same cycle k (combinational) → mem command low from k+1.
- State sequence for a transaction: BUSY from t+1 to k, RELEASE at k+1, IDLE at k+2. The earliest next grant is decided at edge k+2, with its command driven from k+3.
- Minimum occupancy per transaction: 3 cycles, plus memory latency.
- The other client's request is held pending, with no loss, for the whole transaction. It wins the next IDLE arbitration if the just-served client requests again.
- mem_ready is in the cycle's combinational path only through cN_ready and cN_rdata. All mem_* outputs are flop outputs.

## Test plan
- Reset: drive proc_reset low asynchronously in the middle of a BUSY read → mem_read=0, state=IDLE and both readies 0 before the next edge; after release, no command until a new request.
- Single read: c1_read, c1_addr=28'h0000123, memory ready after 3 cycles with rdata=128'hA5…A5 → mem_read high for exactly 3 cycles with mem_addr=28'h0000123; c1_ready pulses 1 cycle; c1_rdata matches; c0_ready stays 0.
- Simultaneous requests after reset: c0_read and c1_write both held → c0 is served first, then c1 (mem_write with c1's wdata); grants alternate c0, c1, c0, c1 over 4 transactions while both keep requesting.
- Registered-request release: client keeps c0_read high for 1 cycle after c0_ready → no second grant to c0; it must issue a new request to be served again.
- Stray mem_ready: pulse mem_ready in IDLE and in RELEASE → no cN_ready, no state change.
- Write-while-read conflict: c1_read and c1_write both high, addr=28'h0ABCDEF → exactly one mem_write, never a mem_read; no cycle with both commands high.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Block-memory command/response bundle between a cache, the arbiter and the memory model.
// The master side issues read/write commands; the slave side answers with ready and read data.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output read, write, addr, wdata, input rdata, ready);
    modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 128-bit block memory port between the instruction
// cache (client 0) and the data cache (client 1); one block transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.slave  c0,
    mem_arbiter_if.slave  c1,
    mem_arbiter_if.master mem
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              grant_idx;

    logic              req0;
    logic              req1;
    logic              pick;
    logic              pick_write;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;
    logic              done;

    // Arbitration: a lone requester wins outright, a tie goes to whoever was not served last.
    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path can infer a latch.
        req0       = c0.read | c0.write;
        req1       = c1.read | c1.write;
        pick       = 1'b0;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = 1'b1;
        end
        pick_write = pick ? c1.write : c0.write;
        pick_addr  = pick ? c1.addr  : c0.addr;
        pick_wdata = pick ? c1.wdata : c0.wdata;
    end

    // Completion reaches only the granted client, and only while a command is outstanding.
    assign done     = (state == S_BUSY) && mem.ready;
    assign c0.ready = done && !grant_idx;
    assign c1.ready = done &&  grant_idx;
    assign c0.rdata = mem.rdata;
    assign c1.rdata = mem.rdata;

    always_ff @(posedge clk or negedge proc_reset) begin
        if (!proc_reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            grant_idx  <= 1'b0;
            mem.read   <= 1'b0;
            mem.write  <= 1'b0;
            mem.addr   <= '0;
            mem.wdata  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        grant_idx  <= pick;
                        last_grant <= pick;
                        mem.write  <= pick_write;
                        mem.read   <= ~pick_write;
                        mem.addr   <= pick_addr;
                        mem.wdata  <= pick_wdata;
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem.ready) begin
                        mem.read  <= 1'b0;
                        mem.write <= 1'b0;
                        mem.addr  <= '0;
                        mem.wdata <= '0;
                        state     <= S_RELEASE;
                    end
                end
                // Dead cycle so the finished client can drop its registered request.
                S_RELEASE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule
